// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-access stage between execute and a word-organised data memory.
//   Takes one load/store at a time and turns it into word-aligned accesses
//   with byte strobes. Accesses that straddle a word boundary become two
//   back-to-back word accesses (or an error response when SPLIT_EN=0).
//   Load data is reassembled from one or two words, then sign- or
//   zero-extended to 32 bits.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   req_valid/req_ready     request handshake (accepted only in IDLE)
//   req_write               1 = store, 0 = load
//   req_size                00 word, 01 half, 10 byte, 11 reserved
//   req_unsigned            loads: 1 = zero-extend, 0 = sign-extend
//   req_addr, req_wdata     byte address, right-justified store data
//   resp_valid              one-cycle completion pulse
//   resp_rdata, resp_err    extended load data; error flag
//   mem_en, mem_we          memory access / write this cycle
//   mem_addr                word-aligned byte address
//   mem_wstrb, mem_wdata    byte lane enables and lane-aligned data
//   mem_rdata               read data, valid the cycle after a read
//
// States
//   IDLE | waiting for a request, req_ready=1
//   A0   | first (or only) word access
//   A1   | second word access of a split request
//   WAIT | last read data arrives on mem_rdata
//   RESP | resp_valid pulse
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter bit          SPLIT_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wstrb,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [2:0] {IDLE, A0, A1, WAIT, RESP} state_t;

  state_t state, state_nxt;

  logic                  l_write;
  logic [1:0]            l_size;
  logic                  l_unsigned;
  logic [ADDR_WIDTH-1:0] l_addr;
  logic [31:0]           l_wdata;
  logic [31:0]           lo_word;

  // Request fields in effect: live inputs while IDLE (the accept cycle),
  // latched copies afterwards. Lets every output be registered from the
  // next-state decode without a dead cycle after accept.
  logic                  f_write;
  logic [1:0]            f_size;
  logic                  f_unsigned;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic [31:0]           f_wdata;

  always_comb begin
    if (state == IDLE) begin
      f_write    = req_write;
      f_size     = req_size;
      f_unsigned = req_unsigned;
      f_addr     = req_addr;
      f_wdata    = req_wdata;
    end else begin
      f_write    = l_write;
      f_size     = l_size;
      f_unsigned = l_unsigned;
      f_addr     = l_addr;
      f_wdata    = l_wdata;
    end
  end

  logic [1:0]            ofs;
  logic [2:0]            nbytes;
  logic [3:0]            bmask;
  logic                  crosses;
  logic [7:0]            lane_mask;
  logic [63:0]           lane_data;
  logic [ADDR_WIDTH-1:0] addr_lo;
  logic [ADDR_WIDTH-1:0] addr_hi;

  assign ofs = f_addr[1:0];

  always_comb begin
    case (f_size)
      2'b00:   begin nbytes = 3'd4; bmask = 4'b1111; end
      2'b01:   begin nbytes = 3'd2; bmask = 4'b0011; end
      2'b10:   begin nbytes = 3'd1; bmask = 4'b0001; end
      default: begin nbytes = 3'd0; bmask = 4'b0000; end
    endcase
  end

  assign crosses = ({1'b0, ofs} + nbytes) > 3'd4;

  // Shifting across a 2-word window: the low half feeds the A0 access, the
  // high half is exactly the spill-over into the next word for A1.
  assign lane_mask = {4'b0000, bmask} << ofs;
  assign lane_data = {32'h0, f_wdata} << {ofs, 3'b000};

  assign addr_lo = {f_addr[ADDR_WIDTH-1:2], 2'b00};
  assign addr_hi = addr_lo + ADDR_WIDTH'(4);

  // Load assembly, used in WAIT when the final word is on mem_rdata.
  logic [31:0] word_lo;
  logic [31:0] word_hi;
  logic [31:0] load_shift;
  logic [31:0] load_ext;

  assign word_lo    = crosses ? lo_word : mem_rdata;
  assign word_hi    = crosses ? mem_rdata : 32'h0;
  assign load_shift = 32'({word_hi, word_lo} >> {ofs, 3'b000});

  always_comb begin
    case (f_size)
      2'b00:   load_ext = load_shift;
      2'b01:   load_ext = f_unsigned ? {16'h0, load_shift[15:0]}
                                     : {{16{load_shift[15]}}, load_shift[15:0]};
      2'b10:   load_ext = f_unsigned ? {24'h0, load_shift[7:0]}
                                     : {{24{load_shift[7]}}, load_shift[7:0]};
      default: load_ext = 32'h0;
    endcase
  end

  logic                  ready_nxt;
  logic                  resp_valid_nxt;
  logic                  resp_err_nxt;
  logic [31:0]           resp_rdata_nxt;
  logic                  mem_en_nxt;
  logic                  mem_we_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [3:0]            mem_wstrb_nxt;
  logic [31:0]           mem_wdata_nxt;

  always_comb begin
    state_nxt      = state;
    resp_err_nxt   = 1'b0;
    resp_rdata_nxt = 32'h0;
    mem_addr_nxt   = '0;
    mem_wstrb_nxt  = 4'b0000;
    mem_wdata_nxt  = 32'h0;

    case (state)
      IDLE: begin
        if (req_valid) begin
          if (f_size == 2'b11 || (crosses && !SPLIT_EN)) begin
            state_nxt    = RESP;
            resp_err_nxt = 1'b1;
          end else begin
            state_nxt = A0;
          end
        end
      end
      A0:      state_nxt = crosses ? A1 : (f_write ? RESP : WAIT);
      A1:      state_nxt = f_write ? RESP : WAIT;
      WAIT: begin
        state_nxt      = RESP;
        resp_rdata_nxt = load_ext;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    ready_nxt      = (state_nxt == IDLE);
    resp_valid_nxt = (state_nxt == RESP);
    mem_en_nxt     = (state_nxt == A0) || (state_nxt == A1);
    mem_we_nxt     = mem_en_nxt && f_write;

    if (state_nxt == A0) begin
      mem_addr_nxt = addr_lo;
      if (f_write) begin
        mem_wstrb_nxt = lane_mask[3:0];
        mem_wdata_nxt = lane_data[31:0];
      end
    end else if (state_nxt == A1) begin
      mem_addr_nxt = addr_hi;
      if (f_write) begin
        mem_wstrb_nxt = lane_mask[7:4];
        mem_wdata_nxt = lane_data[63:32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wstrb  <= 4'b0000;
      mem_wdata  <= 32'h0;
      l_write    <= 1'b0;
      l_size     <= 2'b00;
      l_unsigned <= 1'b0;
      l_addr     <= '0;
      l_wdata    <= 32'h0;
      lo_word    <= 32'h0;
    end else begin
      state      <= state_nxt;
      req_ready  <= ready_nxt;
      resp_valid <= resp_valid_nxt;
      resp_err   <= resp_err_nxt;
      resp_rdata <= resp_rdata_nxt;
      mem_en     <= mem_en_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wstrb  <= mem_wstrb_nxt;
      mem_wdata  <= mem_wdata_nxt;
      if (state == IDLE && req_valid) begin
        l_write    <= req_write;
        l_size     <= req_size;
        l_unsigned <= req_unsigned;
        l_addr     <= req_addr;
        l_wdata    <= req_wdata;
      end
      // In A1 the bus shows the A0 read result: that is the low word.
      if (state == A1) begin
        lo_word <= mem_rdata;
      end
    end
  end

endmodule
